dram_port_arbiter: RTL and testbench

Arbitrates the single DRAM/cache port between the instruction-fetch path (IFR stage, DRAM channel) and the MEM-stage load/store path. Data accesses win by default. A streak counter stops a run of loads/stores from starving fetch. The block owns the memory-port handshake, registers each granted request and returns read data to its owner as a one-cycle ready pulse that the pipeline stages use as their `dram_data_ready`.

---
 rtl/rvcpu_mem_pkg.sv | 6 +
 rtl/dram_port_arbiter_if.sv | 31 +++
 rtl/dram_port_arbiter.sv | 62 ++++++
 tb/tb_dram_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_mem_pkg.sv
// rvcpu_mem_pkg: shared memory-port widths and arbiter state encoding
package rvcpu_mem_pkg;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} arb_state_t;
endpackage

// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: fetch, load/store and memory-port signals of the arbiter
interface dram_port_arbiter_if;
  import rvcpu_mem_pkg::*;
  logic                  i_req;
  logic [MEM_ADDR_W-1:0] i_addr;
  logic [31:0]           i_rdata;
  logic                  i_ready;
  logic                  d_req;
  logic                  d_we;
  logic [MEM_ADDR_W-1:0] d_addr;
  logic [MEM_DATA_W-1:0] d_wdata;
  logic [7:0]            d_wmask;
  logic [MEM_DATA_W-1:0] d_rdata;
  logic                  d_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic [7:0]            mem_wmask;
  logic [MEM_DATA_W-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  busy;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, busy
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one memory port between fetch and load/store, data first with a starvation guard
module dram_port_arbiter
  import rvcpu_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input logic clk,
  input logic reset,
  dram_port_arbiter_if.slave bus
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  arb_state_t state, state_nxt;
  logic [3:0] d_streak;
  logic grant_i, grant_d, done;
  function automatic logic pick_d(input logic i_req, input logic d_req, input logic [3:0] streak);
    return d_req && !(i_req && streak == STREAK_MAX);
  endfunction
  always_comb begin
    grant_d   = state == IDLE && pick_d(bus.i_req, bus.d_req, d_streak);
    grant_i   = state == IDLE && bus.i_req && !grant_d;
    done      = state != IDLE && bus.mem_ready;
    state_nxt = grant_d ? D_BUSY : grant_i ? I_BUSY : done ? IDLE : state;
  end
  // mem_ready in IDLE never reaches done, so a stray completion is dropped here
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      d_streak      <= '0;
      bus.busy      <= 1'b0;
      bus.i_ready   <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
    end else begin
      state       <= state_nxt;
      bus.busy    <= state_nxt != IDLE;
      bus.i_ready <= done && state == I_BUSY;
      bus.d_ready <= done && state == D_BUSY;
      if (done && state == I_BUSY)
        bus.i_rdata <= bus.mem_addr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      if (done && state == D_BUSY)
        bus.d_rdata <= bus.mem_rdata;
      if (state == IDLE)
        d_streak <= (!bus.i_req || grant_i) ? 4'd0 :
                    (grant_d && d_streak != STREAK_MAX) ? d_streak + 4'd1 : d_streak;
      if (grant_d || grant_i) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= grant_d && bus.d_we;
        bus.mem_addr  <= grant_d ? bus.d_addr : bus.i_addr;
        bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
        bus.mem_wmask <= grant_d ? bus.d_wmask : '0;
      end else if (done) begin
        bus.mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: scoreboard bench with queued requesters, a latency-randomised memory and a grant-order model
module tb_dram_port_arbiter;
  import rvcpu_mem_pkg::*;
  localparam int MAXD = 4;
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } dreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dram_port_arbiter_if bus();
  dram_port_arbiter #(.MAX_D_STREAK(MAXD)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0, bad = 0, cyc = 0;
  int i_pulses = 0, d_pulses = 0, i_rise = 0, i_rdy = 0, fix_lat = -1;
  bit spur = 1'b0;
  string glog = "";
  logic [63:0] mem [logic [60:0]];
  logic [63:0] ref_mem [logic [60:0]];
  logic [63:0] i_cmds[$];
  dreq_t d_cmds[$];
  logic [31:0] exp_i[$];
  logic [64:0] exp_d[$];

  function automatic logic [63:0] init_word(logic [60:0] w);
    return {w[31:0] ^ 32'hA5C3_0F1E, ~w[31:0] ^ {w[28:0], 3'b101}};
  endfunction
  function automatic logic [63:0] ref_rd(logic [63:0] a);
    return ref_mem.exists(a[63:3]) ? ref_mem[a[63:3]] : init_word(a[63:3]);
  endfunction
  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] m);
    for (int b = 0; b < 8; b++) if (m[b]) old[8*b +: 8] = wd[8*b +: 8];
    return old;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic check_s(string name, string act, string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s want %s", name, act, exp);
    end
  endtask
  task automatic wait_pulses(int ni, int nd, string name);
    int k = 0;
    while ((i_pulses < ni || d_pulses < nd) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk); #1;
    total++;
    if (i_pulses != ni || d_pulses != nd) begin
      bad++;
      $display("FAIL %s: pulses i=%0d d=%0d want i=%0d d=%0d", name, i_pulses, d_pulses, ni, nd);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // fetch requester: holds i_req until i_ready, issues queued fetches back to back
  initial begin
    logic [63:0] w;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        bus.i_req = 1'b0;
        continue;
      end
      if (bus.i_req && bus.i_ready) bus.i_req = 1'b0;
      if (!bus.i_req && i_cmds.size() > 0) begin
        bus.i_addr = i_cmds.pop_front();
        w = ref_rd(bus.i_addr);
        exp_i.push_back(bus.i_addr[2] ? w[63:32] : w[31:0]);
        bus.i_req = 1'b1;
        i_rise = cyc;
      end
    end
  end

  // data requester: reference memory is updated in issue order
  initial begin
    dreq_t c;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_wmask = '0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        bus.d_req = 1'b0;
        continue;
      end
      if (bus.d_req && bus.d_ready) bus.d_req = 1'b0;
      if (!bus.d_req && d_cmds.size() > 0) begin
        c = d_cmds.pop_front();
        bus.d_we = c.we;
        bus.d_addr = c.addr;
        bus.d_wdata = c.wdata;
        bus.d_wmask = c.wmask;
        if (c.we) begin
          ref_mem[c.addr[63:3]] = merge(ref_rd(c.addr), c.wdata, c.wmask);
          exp_d.push_back({1'b0, 64'h0});
        end else begin
          exp_d.push_back({1'b1, ref_rd(c.addr)});
        end
        bus.d_req = 1'b1;
      end
    end
  end

  // memory: answers each mem_req after 0..3 extra cycles (or fix_lat)
  initial begin
    int lat;
    logic [60:0] wi;
    logic [63:0] old;
    lat = -1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #3;
      bus.mem_ready = 1'b0;
      if (spur) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        continue;
      end
      if (reset || !bus.mem_req) lat = -1;
      else begin
        if (lat < 0) lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 3));
        if (lat == 0) begin
          wi = bus.mem_addr[63:3];
          old = mem.exists(wi) ? mem[wi] : init_word(wi);
          if (bus.mem_we) begin
            mem[wi] = merge(old, bus.mem_wdata, bus.mem_wmask);
            bus.mem_rdata = {$urandom, $urandom};
          end else bus.mem_rdata = old;
          bus.mem_ready = 1'b1;
          lat = -1;
        end else lat--;
      end
    end
  end

  // monitor: ready pulses against the scoreboard, grants against the arbitration rules
  initial begin
    int streak;
    bit pend, gd;
    dreq_t e;
    logic [64:0] xd;
    streak = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.i_ready && bus.d_ready) check("both ready", 1, 0);
      if (bus.i_ready) begin
        i_pulses++;
        i_rdy = cyc;
        if (exp_i.size() == 0) check("unexpected i_ready", 1, 0);
        else check("i_rdata", bus.i_rdata, exp_i.pop_front());
      end
      if (bus.d_ready) begin
        d_pulses++;
        if (exp_d.size() == 0) check("unexpected d_ready", 1, 0);
        else begin
          xd = exp_d.pop_front();
          if (xd[64]) check("d_rdata", bus.d_rdata, xd[63:0]);
        end
      end
      if (reset) begin
        streak = 0;
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        check("grant mem_req", bus.mem_req, 1);
        check("grant mem_addr", bus.mem_addr, e.addr);
        check("grant mem_we", bus.mem_we, e.we);
        check("grant mem_wmask", bus.mem_wmask, e.wmask);
        if (e.we) check("grant mem_wdata", bus.mem_wdata, e.wdata);
        pend = 1'b0;
      end else if (!bus.mem_req) begin
        gd = bus.d_req && !(bus.i_req && streak == MAXD);
        if (gd) begin
          e = '{bus.d_we, bus.d_addr, bus.d_wdata, bus.d_wmask};
          streak = bus.i_req ? (streak < MAXD ? streak + 1 : streak) : 0;
          glog = {glog, "D"};
          pend = 1'b1;
        end else if (bus.i_req) begin
          e = '{1'b0, bus.i_addr, 64'h0, 8'h0};
          streak = 0;
          glog = {glog, "I"};
          pend = 1'b1;
        end else streak = 0;
      end
    end
  end

  initial begin
    int ni, nd, k;
    logic [63:0] a0;
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_req", bus.mem_req, 0);
    check("rst busy", bus.busy, 0);
    check("rst i_ready", bus.i_ready, 0);
    check("rst d_ready", bus.d_ready, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst mem_wmask", bus.mem_wmask, 0);
    check("rst i_rdata", bus.i_rdata, 0);
    check("rst d_rdata", bus.d_rdata, 0);
    reset = 1'b0;
    // lone fetch, memory latency 3
    mem[61'h1000_0000] = 64'h1111_2222_3333_4444;
    ref_mem[61'h1000_0000] = 64'h1111_2222_3333_4444;
    fix_lat = 3;
    i_cmds.push_back(64'h8000_0004);
    wait_pulses(1, 0, "lone fetch");
    check("fetch latency", i_rdy - i_rise, 5);
    // collision: data wins
    fix_lat = -1;
    glog = "";
    d_cmds.push_back('{1'b0, 64'h9000_0000, 64'h0, 8'h0});
    i_cmds.push_back(64'h8000_0008);
    wait_pulses(2, 1, "collision");
    check_s("collision order", glog, "DI");
    // starvation guard
    glog = "";
    i_cmds.push_back(64'h8000_0010);
    for (int j = 0; j < 6; j++) d_cmds.push_back('{1'b0, 64'h9000_0000 + 64'(8 * j), 64'h0, 8'h0});
    wait_pulses(3, 7, "streak");
    check_s("streak order", glog, "DDDDIDD");
    // store then load back
    glog = "";
    d_cmds.push_back('{1'b1, 64'h9000_0010, 64'hDEAD_BEEF_0123_4567, 8'h0F});
    d_cmds.push_back('{1'b0, 64'h9000_0010, 64'h0, 8'h0});
    wait_pulses(3, 9, "store");
    check_s("store order", glog, "DD");
    // reset two cycles into a data transaction
    fix_lat = 10;
    d_cmds.push_back('{1'b0, 64'h9000_0020, 64'h0, 8'h0});
    k = 0;
    while (!bus.mem_req && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("d grant seen", bus.mem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_d.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("post-reset mem_req", bus.mem_req, 0);
    check("post-reset busy", bus.busy, 0);
    fix_lat = -1;
    repeat (15) @(posedge clk);
    i_cmds.push_back(64'h8000_0018);
    wait_pulses(4, 9, "after reset");
    // random traffic
    ni = 4;
    nd = 9;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0 && i_cmds.size() < 3) begin
        i_cmds.push_back(64'h8000_0000 + 64'(4 * $urandom_range(0, 63)));
        ni++;
      end
      if ($urandom_range(0, 2) == 0 && d_cmds.size() < 3) begin
        d_cmds.push_back('{1'($urandom_range(0, 1)), 64'h9000_0000 + 64'(8 * $urandom_range(0, 15)),
                           {$urandom, $urandom}, 8'($urandom)});
        nd++;
      end
    end
    wait_pulses(ni, nd, "random");
    // stray mem_ready while idle
    repeat (3) @(posedge clk);
    #1;
    a0 = bus.mem_addr;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check("spurious busy", bus.busy, 0);
    check("spurious mem_req", bus.mem_req, 0);
    repeat (3) @(posedge clk);
    #1;
    check("spurious mem_addr", bus.mem_addr, a0);
    check("spurious pulses", i_pulses + d_pulses, ni + nd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
